uart_tx: RTL and testbench

//  SPART transmit half: serialises processor-written bytes onto txd as 8N1 frames.

---
 rtl/spart_pkg.sv | 21 ++
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// Shared SPART definitions: transmit FSM encoding, bus register map and
// the default oversample ratio used by uart_tx, uart_rx and the baud generator.
package spart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // ioaddr map; TX and RX share offset 0, direction chosen by iorw
    localparam logic [1:0] ADDR_TX     = 2'b00;
    localparam logic [1:0] ADDR_RX     = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DBL    = 2'b10;
    localparam logic [1:0] ADDR_DBH    = 2'b11;

    localparam int OVERSAMPLE_DEF = 16;

endpackage

// File: rtl/uart_tx.sv
// SPART transmitter: double-buffered 8N1 serialiser. A holding register takes
// processor writes while the shift register drives txd, paced by tx_en ticks.
module uart_tx
    import spart_pkg::*;
#(
    parameter int         DATA_W     = 8,
    parameter int         OVERSAMPLE = OVERSAMPLE_DEF,
    parameter logic [1:0] ADDR_TX_P  = ADDR_TX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              iocs,
    input  logic              iorw,
    input  logic [1:0]        ioaddr,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tbr,
    output logic              tx_busy,
    output logic              txd
);

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              full_q, full_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;

    logic wr;
    logic bit_end;
    logic load;

    assign wr      = iocs & ~iorw & (ioaddr == ADDR_TX_P);
    assign bit_end = tx_en & (tick_q == TICK_LAST);
    // Stop-bit completion reloads directly so back-to-back frames have no idle gap
    assign load    = full_q & ((state_q == TX_IDLE) |
                               ((state_q == TX_STOP) & bit_end));

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        hold_d  = hold_q;
        shift_d = shift_q;
        full_d  = full_q;

        if (state_q != TX_IDLE && tx_en)
            tick_d = bit_end ? '0 : tick_q + 1'b1;

        case (state_q)
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST)
                        state_d = TX_STOP;
                    else
                        bit_d = bit_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_end)
                    state_d = TX_IDLE;
            end
            default: ;
        endcase

        // A tick landing on the load cycle is discarded: tick_cnt restarts at 0
        if (load) begin
            state_d = TX_START;
            tick_d  = '0;
            shift_d = hold_q;
            full_d  = 1'b0;
        end

        // Holding register frees up on a load, so a coincident write still lands
        if (wr && (!full_q || load)) begin
            hold_d = tx_data;
            full_d = 1'b1;
        end

        busy_d = (state_d != TX_IDLE);
        case (state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TX_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            hold_q  <= '0;
            shift_q <= '0;
            full_q  <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            shift_q <= shift_d;
            full_q  <= full_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign tbr     = ~full_q;
    assign tx_busy = busy_q;
    assign txd     = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: stimulus pushes expected bytes, a tick-driven
// line monitor decodes txd and compares each tick sample against the expected frame.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       tx_en;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] tx_data;
    logic       tbr;
    logic       tx_busy;
    logic       txd;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    // tick generator state
    bit ten = 1'b1;
    int tcnt = 0;

    // monitor state
    bit         mon_active = 1'b0;
    bit         mon_orphan = 1'b0;
    int         mon_nt     = 0;
    int         mon_gap    = 1000;
    int         last_gap   = 1000;
    int         frames     = 0;
    logic [9:0] mon_frame  = '1;

    uart_tx #(.DATA_W(8), .OVERSAMPLE(16), .ADDR_TX_P(2'b00)) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_en   (tx_en),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .tx_data (tx_data),
        .tbr     (tbr),
        .tx_busy (tx_busy),
        .txd     (txd)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // tx_en: one-clk pulse every 4 clks, changed just after posedge
    initial begin
        tx_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ten) begin
                tx_en = (tcnt == 3);
                tcnt  = (tcnt + 1) % 4;
            end else begin
                tx_en = 1'b0;
            end
        end
    end

    // Line monitor: one sample per tick, 16 per bit, 10 bits per frame
    always @(negedge clk) begin
        if (!rst) begin
            mon_active = 1'b0;
            mon_orphan = 1'b0;
            mon_nt     = 0;
        end else if (tx_en) begin
            if (!mon_active) begin
                if (txd == 1'b0) begin
                    mon_active = 1'b1;
                    mon_nt     = 0;
                    last_gap   = mon_gap;
                    mon_gap    = 0;
                    if (exp_q.size() == 0) begin
                        mon_orphan = 1'b1;
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: start bit seen, expected no frame at %0t", $time);
                    end else begin
                        mon_orphan = 1'b0;
                        mon_frame  = {1'b1, exp_q.pop_front(), 1'b0};
                    end
                end else begin
                    mon_gap++;
                end
            end
            if (mon_active) begin
                if (!mon_orphan)
                    check("txd_tick", 32'(txd), 32'(mon_frame[mon_nt/16]));
                mon_nt++;
                if (mon_nt == 160) begin
                    mon_active = 1'b0;
                    frames++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] d, input logic rw, input logic [1:0] a);
        iocs    = 1'b1;
        iorw    = rw;
        ioaddr  = a;
        tx_data = d;
        cyc();
        iocs    = 1'b0;
        iorw    = 1'b1;
        ioaddr  = 2'b00;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_active || tx_busy) && n < 4000) begin
            cyc();
            n++;
        end
        check({name, "_drain_timeout"}, 32'(n >= 4000), 32'd0);
        repeat (20) cyc();
        check({name, "_busy_after"}, 32'(tx_busy), 32'd0);
        check({name, "_tbr_after"}, 32'(tbr), 32'd1);
        check({name, "_txd_idle"}, 32'(txd), 32'd1);
    endtask

    task automatic wait_bit(input int fidx, input string name);
        int n;
        n = 0;
        while (!(mon_active && (mon_nt / 16) == fidx) && n < 2000) begin
            cyc();
            n++;
        end
        check({name, "_wait_timeout"}, 32'(n >= 2000), 32'd0);
    endtask

    initial begin
        int f0;
        rst     = 1'b0;
        iocs    = 1'b0;
        iorw    = 1'b1;
        ioaddr  = 2'b00;
        tx_data = 8'h00;
        repeat (3) cyc();
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_tbr", 32'(tbr), 32'd1);
        check("reset_busy", 32'(tx_busy), 32'd0);
        rst = 1'b1;

        // 1: idle line
        for (int i = 0; i < 100; i++) begin
            cyc();
            check("idle_txd", 32'(txd), 32'd1);
            check("idle_tbr", 32'(tbr), 32'd1);
            check("idle_busy", 32'(tx_busy), 32'd0);
        end

        // 2: single frame, tbr low for exactly one clock
        exp_q.push_back(8'hA5);
        bus_write(8'hA5, 1'b0, 2'b00);
        @(negedge clk);
        check("a5_tbr_low", 32'(tbr), 32'd0);
        @(negedge clk);
        check("a5_tbr_back", 32'(tbr), 32'd1);
        check("a5_busy", 32'(tx_busy), 32'd1);
        check("a5_start", 32'(txd), 32'd0);
        drain("a5");

        // 3: second byte written during bit 2, follows with no gap
        f0 = frames;
        exp_q.push_back(8'h5A);
        bus_write(8'h5A, 1'b0, 2'b00);
        wait_bit(3, "b2b");
        exp_q.push_back(8'h3C);
        bus_write(8'h3C, 1'b0, 2'b00);
        check("b2b_tbr_held", 32'(tbr), 32'd0);
        wait_bit(9, "b2b_stop");
        check("b2b_tbr_stop", 32'(tbr), 32'd0);
        drain("b2b");
        check("b2b_frames", 32'(frames - f0), 32'd2);
        check("b2b_gap", 32'(last_gap), 32'd0);

        // 4: third write while holding is full is dropped
        f0 = frames;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        bus_write(8'h11, 1'b0, 2'b00);
        cyc();
        bus_write(8'h22, 1'b0, 2'b00);
        check("drop_tbr_full", 32'(tbr), 32'd0);
        bus_write(8'h33, 1'b0, 2'b00);
        drain("drop");
        repeat (700) cyc();
        check("drop_frames", 32'(frames - f0), 32'd2);

        // 5: reads and other addresses are ignored
        f0 = frames;
        bus_write(8'h77, 1'b1, 2'b00);
        check("ign_read_tbr", 32'(tbr), 32'd1);
        bus_write(8'h77, 1'b0, 2'b01);
        check("ign_addr_tbr", 32'(tbr), 32'd1);
        iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; tx_data = 8'h77;
        cyc();
        iorw = 1'b1;
        check("ign_cs_tbr", 32'(tbr), 32'd1);
        repeat (100) cyc();
        check("ign_busy", 32'(tx_busy), 32'd0);
        check("ign_frames", 32'(frames - f0), 32'd0);

        // 6: reset during data bit 4, then a clean frame
        exp_q.push_back(8'h96);
        bus_write(8'h96, 1'b0, 2'b00);
        exp_q.push_back(8'h69);
        bus_write(8'h69, 1'b0, 2'b00);
        wait_bit(5, "rst");
        rst = 1'b0;
        #1;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_tbr", 32'(tbr), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        exp_q.delete();
        repeat (3) cyc();
        rst = 1'b1;
        repeat (50) cyc();
        check("rst_no_pending", 32'(tx_busy), 32'd0);
        f0 = frames;
        exp_q.push_back(8'hC3);
        bus_write(8'hC3, 1'b0, 2'b00);
        drain("rst_new");
        check("rst_new_frames", 32'(frames - f0), 32'd1);

        // 7: tx_en stalled mid-START
        f0 = frames;
        exp_q.push_back(8'h7E);
        bus_write(8'h7E, 1'b0, 2'b00);
        while (!(mon_active && mon_nt == 5)) cyc();
        ten = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (i % 20 == 0) begin
                check("stall_txd", 32'(txd), 32'd0);
                check("stall_busy", 32'(tx_busy), 32'd1);
            end
        end
        ten = 1'b1;
        drain("stall");
        check("stall_frames", 32'(frames - f0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
